// File: rtl/song_pkg.sv
// song_pkg: shared song geometry, scoring constants, FSM encoding and saturating helpers
// for the note scroller.
package song_pkg;
    localparam int SONG_LEN       = 100;
    localparam int PTS_HIT        = 10;
    localparam int PTS_BONUS      = 5;
    localparam int COMBO_BONUS_TH = 10;
    localparam int LANE_RED       = 0;
    localparam int LANE_BLUE      = 1;
    localparam int LANE_YELLOW    = 2;
    localparam int NUM_LANES      = 3;

    typedef enum logic [1:0] {IDLE, LOAD, PLAY, DONE} state_e;

    function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
        logic [8:0] s;
        s = {1'b0, v} + {7'b0, n};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] v, input logic [4:0] n);
        logic [16:0] s;
        s = {1'b0, v} + {12'b0, n};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction
endpackage

// File: rtl/note_scroller_beat_timer.sv
// beat_timer: free-running divider that pulses tick on its terminal count; clear holds it
// at zero so the first tick lands CLK_DIV cycles after clear drops.
module beat_timer #(
    parameter int CLK_DIV = 12500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic clear,
    output logic tick
);
    localparam int W = $clog2(CLK_DIV);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = !clear && cnt_q == W'(CLK_DIV - 1);
        cnt_d = (clear || tick) ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
endmodule

// File: rtl/note_scroller.sv
// note_scroller: latches three lane patterns, scrolls them one column per beat past the hit
// column, judges key presses and keeps score, combo and hit/miss counts.
module note_scroller
    import song_pkg::*;
#(
    parameter int CLK_DIV = 12500000,
    parameter int WINDOW  = 8
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                start,
    input  logic [SONG_LEN-1:0] song_red,
    input  logic [SONG_LEN-1:0] song_blue,
    input  logic [SONG_LEN-1:0] song_yellow,
    input  logic [7:0]          total_notes,
    input  logic                key_red,
    input  logic                key_blue,
    input  logic                key_yellow,
    output logic [WINDOW-1:0]   win_red,
    output logic [WINDOW-1:0]   win_blue,
    output logic [WINDOW-1:0]   win_yellow,
    output logic                beat_tick,
    output logic [15:0]         score,
    output logic [7:0]          combo,
    output logic [7:0]          notes_hit,
    output logic [7:0]          notes_missed,
    output logic                playing,
    output logic                done,
    output logic                full_combo
);
    localparam logic [4:0] PTS_NORM = 5'(PTS_HIT);
    localparam logic [4:0] PTS_FULL = 5'(PTS_HIT + PTS_BONUS);

    state_e                              state_q, state_d;
    logic [NUM_LANES-1:0][SONG_LEN-1:0]  lane_q, lane_d;
    logic [NUM_LANES-1:0]                key, key_prev_q, key_rise;
    logic                                start_prev_q, start_rise;
    logic [6:0]                          beat_q, beat_d;
    logic [7:0]                          total_q, total_d;
    logic [15:0]                         score_q, score_d;
    logic [7:0]                          combo_q, combo_d, hit_q, hit_d, miss_q, miss_d;
    logic [1:0]                          n_miss;
    logic                                tick;

    beat_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clock (clock),
        .resetn(resetn),
        .clear (state_q != PLAY),
        .tick  (tick)
    );

    assign key        = {key_yellow, key_blue, key_red};
    assign key_rise   = key & ~key_prev_q;
    assign start_rise = start && !start_prev_q;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        beat_d  = beat_q;
        total_d = total_q;
        score_d = score_q;
        combo_d = combo_q;
        hit_d   = hit_q;
        miss_d  = miss_q;
        n_miss  = 2'd0;
        case (state_q)
            IDLE: state_d = start_rise ? LOAD : IDLE;
            LOAD: begin
                lane_d  = {song_yellow, song_blue, song_red};
                total_d = total_notes;
                beat_d  = '0;
                score_d = '0;
                combo_d = '0;
                hit_d   = '0;
                miss_d  = '0;
                state_d = PLAY;
            end
            PLAY: begin
                // Lanes are judged in index order so the combo bonus sees earlier same-cycle hits.
                for (int l = 0; l < NUM_LANES; l++)
                    if (key_rise[l]) begin
                        if (lane_d[l][0]) begin
                            lane_d[l][0] = 1'b0;
                            hit_d   = sat_add8(hit_d, 2'd1);
                            score_d = sat_add16(score_d, combo_d >= 8'(COMBO_BONUS_TH) ? PTS_FULL : PTS_NORM);
                            combo_d = sat_add8(combo_d, 2'd1);
                        end else begin
                            combo_d = '0;
                        end
                    end
                if (tick) begin
                    n_miss  = {1'b0, lane_d[0][0]} + {1'b0, lane_d[1][0]} + {1'b0, lane_d[2][0]};
                    miss_d  = sat_add8(miss_d, n_miss);
                    combo_d = n_miss != 2'd0 ? 8'd0 : combo_d;
                    for (int l = 0; l < NUM_LANES; l++)
                        lane_d[l] = {1'b0, lane_d[l][SONG_LEN-1:1]};
                    beat_d  = beat_q + 7'd1;
                    state_d = beat_q == 7'(SONG_LEN - 1) ? DONE : PLAY;
                end
            end
            default: state_d = start_rise ? LOAD : DONE;
        endcase
    end

    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state_q      <= IDLE;
            lane_q       <= '0;
            key_prev_q   <= '0;
            start_prev_q <= 1'b0;
            beat_q       <= '0;
            total_q      <= '0;
            score_q      <= '0;
            combo_q      <= '0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            lane_q       <= lane_d;
            key_prev_q   <= key;
            start_prev_q <= start;
            beat_q       <= beat_d;
            total_q      <= total_d;
            score_q      <= score_d;
            combo_q      <= combo_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end

    assign playing      = state_q == PLAY;
    assign done         = state_q == DONE;
    assign full_combo   = done && hit_q == total_q && miss_q == 8'd0;
    assign beat_tick    = tick;
    assign score        = score_q;
    assign combo        = combo_q;
    assign notes_hit    = hit_q;
    assign notes_missed = miss_q;
    assign win_red      = playing ? lane_q[LANE_RED][WINDOW-1:0]    : '0;
    assign win_blue     = playing ? lane_q[LANE_BLUE][WINDOW-1:0]   : '0;
    assign win_yellow   = playing ? lane_q[LANE_YELLOW][WINDOW-1:0] : '0;
endmodule

// File: tb/tb_note_scroller.sv
// tb_note_scroller: directed playthroughs checked every cycle against a beat-index song
// model, plus hand-computed literal expectations at key points.
module tb_note_scroller;
    localparam int CD = 4;
    localparam int WIN = 8;

    logic clock = 0, resetn = 0, start = 0;
    logic [99:0] song_red = 0, song_blue = 0, song_yellow = 0;
    logic [7:0] total_notes = 0;
    logic key_red = 0, key_blue = 0, key_yellow = 0;
    logic [WIN-1:0] win_red, win_blue, win_yellow;
    logic beat_tick, playing, done, full_combo;
    logic [15:0] score;
    logic [7:0] combo, notes_hit, notes_missed;

    int n_pass = 0, n_total = 0;

    note_scroller #(.CLK_DIV(CD), .WINDOW(WIN)) dut (
        .clock(clock), .resetn(resetn), .start(start),
        .song_red(song_red), .song_blue(song_blue), .song_yellow(song_yellow),
        .total_notes(total_notes),
        .key_red(key_red), .key_blue(key_blue), .key_yellow(key_yellow),
        .win_red(win_red), .win_blue(win_blue), .win_yellow(win_yellow),
        .beat_tick(beat_tick), .score(score), .combo(combo),
        .notes_hit(notes_hit), .notes_missed(notes_missed),
        .playing(playing), .done(done), .full_combo(full_combo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Model: the song is a fixed bit array read at the current beat index; hit notes are
    // marked used rather than shifted out.
    int m_mode = 0, m_b = 0, m_cyc = 0, m_score = 0, m_combo = 0, m_hit = 0, m_miss = 0, m_total = 0;
    logic [99:0] m_song [3];
    logic [99:0] m_used [3];
    logic [2:0] m_kprev = 0, m_k;
    logic m_sprev = 0;
    int m_nm;

    initial for (int l = 0; l < 3; l++) begin m_song[l] = 0; m_used[l] = 0; end

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            m_mode = 0; m_b = 0; m_cyc = 0; m_score = 0; m_combo = 0;
            m_hit = 0; m_miss = 0; m_total = 0; m_kprev = 0; m_sprev = 0;
            for (int l = 0; l < 3; l++) begin m_song[l] = 0; m_used[l] = 0; end
        end else begin
            m_k = {key_yellow, key_blue, key_red};
            if (m_mode == 0 || m_mode == 3) begin
                if (start && !m_sprev) m_mode = 1;
            end else if (m_mode == 1) begin
                m_song[0] = song_red; m_song[1] = song_blue; m_song[2] = song_yellow;
                for (int l = 0; l < 3; l++) m_used[l] = 0;
                m_total = total_notes; m_b = 0; m_cyc = 0;
                m_score = 0; m_combo = 0; m_hit = 0; m_miss = 0; m_mode = 2;
            end else begin
                for (int l = 0; l < 3; l++)
                    if (m_k[l] && !m_kprev[l]) begin
                        if (m_song[l][m_b] && !m_used[l][m_b]) begin
                            m_used[l][m_b] = 1'b1;
                            m_score = m_score + (m_combo >= 10 ? 15 : 10);
                            if (m_score > 65535) m_score = 65535;
                            if (m_hit < 255) m_hit++;
                            if (m_combo < 255) m_combo++;
                        end else m_combo = 0;
                    end
                if (m_cyc == CD - 1) begin
                    m_nm = 0;
                    for (int l = 0; l < 3; l++) if (m_song[l][m_b] && !m_used[l][m_b]) m_nm++;
                    m_miss = m_miss + m_nm > 255 ? 255 : m_miss + m_nm;
                    if (m_nm != 0) m_combo = 0;
                    m_b++; m_cyc = 0;
                    if (m_b == 100) m_mode = 3;
                end else m_cyc++;
            end
            m_kprev = m_k;
            m_sprev = start;
        end
    end

    function automatic logic [WIN-1:0] mwin(input int l);
        logic [WIN-1:0] w;
        w = 0;
        for (int i = 0; i < WIN; i++)
            if (m_mode == 2 && m_b + i < 100) w[i] = m_song[l][m_b+i] & ~m_used[l][m_b+i];
        return w;
    endfunction

    always @(posedge clock) begin
        #2;
        chk("beat_tick", beat_tick, m_mode == 2 && m_cyc == CD - 1);
        chk("playing", playing, m_mode == 2);
        chk("done", done, m_mode == 3);
        chk("full_combo", full_combo, m_mode == 3 && m_hit == m_total && m_miss == 0);
        chk("score", score, m_score);
        chk("combo", combo, m_combo);
        chk("notes_hit", notes_hit, m_hit);
        chk("notes_missed", notes_missed, m_miss);
        chk("win_red", win_red, mwin(0));
        chk("win_blue", win_blue, mwin(1));
        chk("win_yellow", win_yellow, mwin(2));
    end

    task automatic do_start;
        @(negedge clock); start = 1;
        @(negedge clock); start = 0;
        @(negedge clock);
    endtask

    task automatic find_tick;
        int n = 0;
        while (beat_tick !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        if (n >= 20) chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_tick;
        find_tick();
        @(negedge clock);
    endtask

    task automatic wait_done;
        int n = 0;
        while (done !== 1'b1 && n < 1000) begin @(negedge clock); n++; end
        chk("done_reached", done, 1);
    endtask

    task automatic tap_red;
        key_red = 1; @(negedge clock); key_red = 0;
    endtask

    initial begin
        #2;
        chk("rst_score", score, 0);
        chk("rst_playing", playing, 0);
        chk("rst_win_red", win_red, 0);
        chk("rst_done", done, 0);
        @(negedge clock); resetn = 1;

        song_red = 100'h1; total_notes = 1;
        do_start();
        key_red = 1; @(negedge clock); key_red = 0;
        chk("t1_hit", notes_hit, 1);
        chk("t1_score", score, 10);
        chk("t1_combo", combo, 1);
        chk("t1_win0", win_red[0], 0);
        chk("t1_tick_early", beat_tick, 0);
        wait_done();
        chk("t1_missed", notes_missed, 0);
        chk("t1_fc", full_combo, 1);

        song_red = 100'b11; total_notes = 2;
        do_start();
        song_red = {100{1'b1}};
        start = 1; @(negedge clock); start = 0;
        wait_tick();
        chk("t2_miss1", notes_missed, 1);
        wait_tick();
        chk("t2_miss2", notes_missed, 2);
        chk("t2_combo", combo, 0);
        chk("t2_score", score, 0);
        chk("t2_playing", playing, 1);
        wait_done();
        chk("t2_fc", full_combo, 0);

        song_red = 100'h1; song_blue = 100'h1; song_yellow = 100'h1; total_notes = 3;
        do_start();
        find_tick();
        key_red = 1; key_blue = 1; key_yellow = 1;
        @(negedge clock);
        key_red = 0; key_blue = 0; key_yellow = 0;
        chk("t3_hit", notes_hit, 3);
        chk("t3_missed", notes_missed, 0);
        chk("t3_score", score, 30);
        chk("t3_combo", combo, 3);
        wait_done();
        chk("t3_fc", full_combo, 1);

        song_red = 100'hFFF; song_blue = 0; song_yellow = 0; total_notes = 12;
        do_start();
        for (int i = 0; i < 12; i++) begin tap_red(); wait_tick(); end
        chk("t4_combo", combo, 12);
        chk("t4_score", score, 130);
        chk("t4_hit", notes_hit, 12);
        wait_done();
        chk("t4_done", done, 1);
        chk("t4_fc", full_combo, 1);

        song_red = 100'hDF; total_notes = 7;
        do_start();
        for (int i = 0; i < 5; i++) begin tap_red(); wait_tick(); end
        chk("t5_combo5", combo, 5);
        tap_red();
        chk("t5_stray_combo", combo, 0);
        chk("t5_stray_score", score, 50);
        wait_tick();
        key_red = 1;
        wait_tick();
        wait_tick();
        key_red = 0;
        chk("t5_hold_hit", notes_hit, 6);
        chk("t5_hold_miss", notes_missed, 1);
        chk("t5_hold_score", score, 60);
        chk("t5_hold_combo", combo, 0);
        wait_done();
        chk("t5_fc", full_combo, 0);

        song_red = {100{1'b1}}; total_notes = 100;
        do_start();
        for (int i = 0; i < 40; i++) wait_tick();
        chk("t6_miss40", notes_missed, 40);
        resetn = 0; #1;
        chk("t6_rst_miss", notes_missed, 0);
        chk("t6_rst_playing", playing, 0);
        chk("t6_rst_win", win_red, 0);
        chk("t6_rst_score", score, 0);
        @(negedge clock); resetn = 1;
        @(negedge clock);
        chk("t6_idle", playing, 0);
        song_red = 100'h1; total_notes = 1;
        do_start();
        chk("t6_replay_playing", playing, 1);
        chk("t6_replay_miss0", notes_missed, 0);
        chk("t6_replay_win", win_red, 8'h01);
        wait_tick();
        chk("t6_replay_miss1", notes_missed, 1);
        wait_done();
        chk("t6_fc", full_combo, 0);

        @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Consumes the three 100-bit lane patterns (red/blue/yellow) and the total_notes count produced by the song loader.
- On start, latches the patterns and scrolls them one column per beat toward a fixed hit column.
- Judges player key presses against the hit column and keeps score, combo and hit/miss counts.
- Exposes a look-ahead window of upcoming notes per lane for the VGA draw stage.

Parameters:
CLK_DIV, 12500000, clock cycles per beat (4 beats/s at 50 MHz); must be >= 2.
WINDOW, 8, number of upcoming columns per lane exposed for display (1..100).

Ports:
clock  in  1  system clock
resetn  in  1  asynchronous active-low reset
start  in  1  level; a rising edge starts or restarts playback
song_red  in  100  red lane pattern; bit 0 plays first
song_blue  in  100  blue lane pattern
song_yellow  in  100  yellow lane pattern
total_notes  in  8  note count of the selected song
key_red  in  1  player key, level, synchronous to clock
key_blue  in  1  player key
key_yellow  in  1  player key
win_red  out  WINDOW  red lane bits [WINDOW-1:0]; bit 0 is the hit column
win_blue  out  WINDOW  blue lane window
win_yellow  out  WINDOW  yellow lane window
beat_tick  out  1  one-cycle pulse on each scroll step
score  out  16  accumulated score, saturating
combo  out  8  current consecutive-hit streak, saturating
notes_hit  out  8  hit count, saturating at 255
notes_missed  out  8  missed-note count, saturating at 255
playing  out  1  high in PLAY
done  out  1  high in DONE
full_combo  out  1  high in DONE when notes_hit == total_notes and notes_missed == 0

Behaviour:
- Reset (async, resetn=0): state IDLE. Lane shift registers, counters, score, combo, beat count, divider and edge-detect history all clear to 0. Every output is 0.
- Edge detection: internal registers on start and the three keys; a rise is current=1 with previous=0. A held key produces only one rise.
- IDLE:
  - On a start rise, go to LOAD.
- LOAD (exactly 1 cycle):
  - Latch song_red/blue/yellow into the lane registers and total_notes into a local register.
  - Clear score, combo, notes_hit, notes_missed, the beat counter (0..99) and the divider.
  - Go to PLAY.
- PLAY, playing=1:
  - The divider counts 0..CLK_DIV-1. On terminal count, beat_tick=1 for one cycle and the divider wraps to 0. The first tick comes CLK_DIV cycles after entering PLAY.
  - Key judge, per lane and each cycle:
    - Key rise with lane bit0=1 is a hit. Clear bit0 (consume the note), notes_hit+1, combo+1, and add score 10, or 15 when combo before this hit is >= 10.
    - Key rise with lane bit0=0 is a stray press. Set combo to 0; score is unchanged.
    - Hits in several lanes in the same cycle each count, applied in the order red, blue, yellow for the combo bonus.
  - On beat_tick:
    - Each lane whose bit0 is still 1 after judging is a miss. notes_missed increases by the number of such lanes (0..3); combo goes to 0 if any lane missed.
    - All lanes then shift right by 1 with 0 shifted into bit 99, and the beat counter increments.
  - Key rise and beat_tick in the same cycle: judge first against the pre-shift bit0. A note hit in that cycle is not also counted as missed.
  - On the tick that takes the beat counter from 99 to 100 (the 100th shift), go to DONE.
  - A start rise during PLAY is ignored.
- DONE, done=1:
  - Counters hold; full_combo is valid; the windows read all zero.
  - A start rise goes to LOAD (replay with the current song_* inputs).
- Saturation: score stops at 0xFFFF. combo, notes_hit and notes_missed stop at 255.
- Latency:
  - win_* reflect the lane registers combinationally from the registers (zero added latency).
  - Counters update on the clock edge after the key rise.
- Song inputs are sampled only in LOAD. Changing them mid-play has no effect.
- Reset mid-operation returns immediately to IDLE with all outputs 0.

Decomposition:
- Shared package song_pkg:
  - SONG_LEN=100
  - PTS_HIT=10
  - PTS_BONUS=5
  - COMBO_BONUS_TH=10
  - State encoding IDLE/LOAD/PLAY/DONE (2-bit)
  - LANE_RED/BLUE/YELLOW indices
- Sub-module beat_timer(clock, resetn, clear, tick), parameterised by CLK_DIV. The divider lives there; note_scroller holds the FSM, lanes and scoring.

Test Plan:
- CLK_DIV=4. Red=100'h1, others 0. Start; press red 2 cycles after LOAD -> notes_hit=1, score=10, combo=1, win_red[0]=0 before the first tick, notes_missed=0.
- Red=100'b11 (bits 0,1), no keys -> notes_missed=1 at tick 1 and 2 at tick 2; combo=0; score=0.
- All three lanes bit0=1. Press red, blue and yellow in the same cycle as beat_tick -> notes_hit=3, notes_missed=0, score=30.
- Lane bits 0..11 set in red, hit each note once per beat -> combo reaches 12; score=10*10+15+15=130; after 100 ticks done=1 and full_combo=1 when total_notes=12.
- Stray red press with bit0=0 at combo=5 -> combo=0, score unchanged. Holding the key across two beats with notes present -> only one hit counted.
- Assert resetn=0 mid-PLAY at beat 40 -> all outputs 0, state IDLE. A later start replays from beat 0 with the counters cleared.
